// File: rtl/sirv_gnrl_vr_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sirv_gnrl_vr_fifo
//  Brief    : Valid/ready FIFO with registered-only outputs and arbitrary depth.
//  Revision : 1.0 - initial release
// ============================================================================
module sirv_gnrl_vr_fifo #(
    parameter int DP = 4,
    parameter int DW = 32,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);

    localparam int            C_AW    = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [C_AW-1:0] C_LAST  = C_AW'(DP - 1);
    localparam logic [CW-1:0]   C_DEPTH = CW'(DP);

    logic [DW-1:0]   mem [DP];
    logic [C_AW-1:0] wptr_q, wptr_d;
    logic [C_AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            w_push;
    logic            w_pop;

    // Ready/valid come only from the occupancy flop, never from the other side.
    assign full   = (cnt_q == C_DEPTH);
    assign empty  = (cnt_q == '0);
    assign i_rdy  = !full;
    assign o_vld  = !empty;
    assign cnt    = cnt_q;
    assign o_dat  = mem[rptr_q];
    assign w_push = i_vld & i_rdy;
    assign w_pop  = o_vld & o_rdy;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            // Explicit wrap compare keeps non-power-of-two depths correct.
            if (w_push) begin
                wptr_d = (wptr_q == C_LAST) ? '0 : wptr_q + C_AW'(1);
            end
            if (w_pop) begin
                rptr_d = (rptr_q == C_LAST) ? '0 : rptr_q + C_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is deliberately not reset; a write during a flush is harmless.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem[wptr_q] <= i_dat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sirv_gnrl_vr_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sirv_gnrl_vr_fifo
//  Brief    : Self-checking bench for sirv_gnrl_vr_fifo at depths 4 and 3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sirv_gnrl_vr_fifo;

    localparam int DW = 32;
    localparam int CW = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          a_clr = 1'b0, a_i_vld = 1'b0, a_o_rdy = 1'b0;
    logic [DW-1:0] a_i_dat = '0;
    logic          a_i_rdy, a_o_vld, a_full, a_empty;
    logic [DW-1:0] a_o_dat;
    logic [CW-1:0] a_cnt;

    logic          b_clr = 1'b0, b_i_vld = 1'b0, b_o_rdy = 1'b0;
    logic [DW-1:0] b_i_dat = '0;
    logic          b_i_rdy, b_o_vld, b_full, b_empty;
    logic [DW-1:0] b_o_dat;
    logic [CW-1:0] b_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];

    sirv_gnrl_vr_fifo #(.DP(4), .DW(DW), .CW(CW)) u_dut_a (
        .clk(clk), .reset(reset), .clr(a_clr),
        .i_vld(a_i_vld), .i_rdy(a_i_rdy), .i_dat(a_i_dat),
        .o_vld(a_o_vld), .o_rdy(a_o_rdy), .o_dat(a_o_dat),
        .cnt(a_cnt), .full(a_full), .empty(a_empty)
    );

    sirv_gnrl_vr_fifo #(.DP(3), .DW(DW), .CW(CW)) u_dut_b (
        .clk(clk), .reset(reset), .clr(b_clr),
        .i_vld(b_i_vld), .i_rdy(b_i_rdy), .i_dat(b_i_dat),
        .o_vld(b_o_vld), .o_rdy(b_o_rdy), .o_dat(b_o_dat),
        .cnt(b_cnt), .full(b_full), .empty(b_empty)
    );

    // Reference queues: a beat enters when valid and the queue has room,
    // leaves when the reader is ready and the queue is non-empty.
    always @(posedge clk or posedge reset) begin
        if (reset || a_clr) begin
            qa.delete();
        end else if (a_i_vld && qa.size() < 4) begin
            if (a_o_rdy && qa.size() > 0) void'(qa.pop_front());
            qa.push_back(a_i_dat);
        end else if (a_o_rdy && qa.size() > 0) begin
            void'(qa.pop_front());
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset || b_clr) begin
            qb.delete();
        end else if (b_i_vld && qb.size() < 3) begin
            if (b_o_rdy && qb.size() > 0) void'(qb.pop_front());
            qb.push_back(b_i_dat);
        end else if (b_o_rdy && qb.size() > 0) begin
            void'(qb.pop_front());
        end
    end

    // Protocol assumptions on the writer and occupancy bounds.
    logic          a_wait;
    logic [DW-1:0] a_wdat;
    always @(posedge clk) begin
        if (reset) begin
            a_wait <= 1'b0;
        end else begin
            if (a_wait) assert (a_i_vld && a_i_dat == a_wdat)
                else $error("protocol: writer dropped or changed a pending beat");
            a_wait <= a_i_vld && !a_i_rdy && !a_clr;
            a_wdat <= a_i_dat;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            assert (a_cnt <= 7'd4) else $error("occupancy above depth (A)");
            assert (b_cnt <= 7'd3) else $error("occupancy above depth (B)");
            assert (!(a_full && a_i_rdy)) else $error("ready while full (A)");
            assert (!(a_empty && a_o_vld)) else $error("valid while empty (A)");
            assert (!(b_full && b_i_rdy)) else $error("ready while full (B)");
            assert (!(b_empty && b_o_vld)) else $error("valid while empty (B)");
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({a_o_vld, a_cnt, a_empty, a_full, a_i_rdy} !== {1'b0, 7'd0, 1'b1, 1'b0, 1'b1})
            $display("FAIL reset_a: got vld/cnt/empty/full/rdy=%b want 0_0000000_1_0_1",
                     {a_o_vld, a_cnt, a_empty, a_full, a_i_rdy});
        else n_pass++;
        n_checks++;
        if ({b_o_vld, b_cnt, b_empty, b_full, b_i_rdy} !== {1'b0, 7'd0, 1'b1, 1'b0, 1'b1})
            $display("FAIL reset_b: got vld/cnt/empty/full/rdy=%b want 0_0000000_1_0_1",
                     {b_o_vld, b_cnt, b_empty, b_full, b_i_rdy});
        else n_pass++;
        a_i_vld = 1'b1;
        a_i_dat = 32'h11;
        @(negedge clk);
        a_i_vld = 1'b0;
        n_checks++;
        if ({a_o_vld, a_cnt, a_o_dat} !== {1'b1, 7'd1, 32'h11})
            $display("FAIL one_beat: got vld=%b cnt=%0d dat=%h want 1 1 11", a_o_vld, a_cnt, a_o_dat);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({a_o_vld, a_cnt, a_empty, a_full, a_i_rdy} !== {1'b0, 7'd0, 1'b1, 1'b0, 1'b1})
            $display("FAIL async_reset: got vld/cnt/empty/full/rdy=%b want 0_0000000_1_0_1",
                     {a_o_vld, a_cnt, a_empty, a_full, a_i_rdy});
        else n_pass++;
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        a_o_rdy = 1'b0;
        a_i_vld = 1'b1;
        a_i_dat = 32'hA0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (a_cnt !== CW'(k + 1))
                $display("FAIL fill_cnt%0d: got %0d want %0d", k, a_cnt, k + 1);
            else n_pass++;
            a_i_dat = 32'hA1 + k;
        end
        n_checks++;
        if ({a_full, a_i_rdy} !== 2'b10)
            $display("FAIL fill_full: got full/rdy=%b want 10", {a_full, a_i_rdy});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({a_cnt, a_o_dat} !== {7'd4, 32'hA0})
            $display("FAIL fill_holdoff: got cnt=%0d head=%h want 4 a0", a_cnt, a_o_dat);
        else n_pass++;
        a_o_rdy = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            n_checks++;
            if ({a_o_vld, a_o_dat} !== {1'b1, 32'hA0 + j})
                $display("FAIL drain%0d: got vld=%b dat=%h want 1 %h", j, a_o_vld, a_o_dat, 32'hA0 + j);
            else n_pass++;
            if (j == 2) a_i_vld = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({a_o_vld, a_cnt} !== {1'b0, 7'd0})
            $display("FAIL drain_end: got vld=%b cnt=%0d want 0 0", a_o_vld, a_cnt);
        else n_pass++;
        a_o_rdy = 1'b0;
    endtask

    task automatic test_stream();
        int bad = 0;
        a_i_vld = 1'b1;
        a_o_rdy = 1'b1;
        a_i_dat = 32'h1000;
        for (int c = 1; c <= 101; c++) begin
            @(negedge clk);
            if (c <= 100) begin
                n_checks++;
                if ({a_o_vld, a_cnt, a_o_dat} !== {1'b1, 7'd1, 32'h1000 + c - 1}) begin
                    if (bad < 5)
                        $display("FAIL stream%0d: got vld=%b cnt=%0d dat=%h want 1 1 %h",
                                 c, a_o_vld, a_cnt, a_o_dat, 32'h1000 + c - 1);
                    bad++;
                end else n_pass++;
            end
            if (c < 100) a_i_dat = 32'h1000 + c;
            else         a_i_vld = 1'b0;
        end
        n_checks++;
        if ({a_o_vld, a_cnt} !== {1'b0, 7'd0})
            $display("FAIL stream_end: got vld=%b cnt=%0d want 0 0", a_o_vld, a_cnt);
        else n_pass++;
        a_o_rdy = 1'b0;
    endtask

    task automatic test_nonpow2();
        logic prev_rdy = 1'b1;
        int   bad = 0;
        for (int c = 0; c < 84; c++) begin
            @(negedge clk);
            n_checks++;
            if ({b_o_vld, b_cnt} !== {qb.size() > 0, CW'(qb.size())} ||
                (qb.size() > 0 && b_o_dat !== qb[0])) begin
                if (bad < 5)
                    $display("FAIL dp3_c%0d: got vld=%b cnt=%0d dat=%h want cnt=%0d dat=%h",
                             c, b_o_vld, b_cnt, b_o_dat, qb.size(),
                             (qb.size() > 0) ? qb[0] : 32'h0);
                bad++;
            end else n_pass++;
            if (c >= 80) begin
                b_i_vld = 1'b0;
                b_o_rdy = 1'b1;
            end else begin
                if (!(b_i_vld && !prev_rdy)) begin
                    b_i_vld = 1'($urandom_range(0, 1));
                    b_i_dat = $urandom;
                end
                b_o_rdy = 1'($urandom_range(0, 1));
            end
            prev_rdy = b_i_rdy;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({b_empty, b_cnt} !== {1'b1, 7'd0})
            $display("FAIL dp3_drained: got empty=%b cnt=%0d want 1 0", b_empty, b_cnt);
        else n_pass++;
        b_o_rdy = 1'b0;
    endtask

    task automatic test_flush();
        a_o_rdy = 1'b0;
        a_i_vld = 1'b1;
        a_i_dat = 32'h31;
        @(negedge clk) a_i_dat = 32'h32;
        @(negedge clk) a_i_dat = 32'h33;
        @(negedge clk);
        n_checks++;
        if (a_cnt !== 7'd3)
            $display("FAIL flush_load: got cnt=%0d want 3", a_cnt);
        else n_pass++;
        a_clr   = 1'b1;
        a_i_dat = 32'h55;
        @(negedge clk);
        n_checks++;
        if ({a_o_vld, a_cnt, a_empty} !== {1'b0, 7'd0, 1'b1})
            $display("FAIL flush_clr: got vld=%b cnt=%0d empty=%b want 0 0 1", a_o_vld, a_cnt, a_empty);
        else n_pass++;
        a_clr   = 1'b0;
        a_i_dat = 32'h66;
        @(negedge clk);
        a_i_vld = 1'b0;
        n_checks++;
        if ({a_cnt, a_o_dat} !== {7'd1, 32'h66} || qa.size() != 1)
            $display("FAIL flush_next: got cnt=%0d dat=%h want 1 66", a_cnt, a_o_dat);
        else n_pass++;
        a_o_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_o_vld, a_cnt} !== {1'b0, 7'd0})
            $display("FAIL flush_alone: got vld=%b cnt=%0d want 0 0", a_o_vld, a_cnt);
        else n_pass++;
        a_o_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_i_vld = 1'b1;
        a_i_dat = 32'h21;
        @(negedge clk) a_i_dat = 32'h22;
        @(negedge clk) a_i_vld = 1'b0;
        n_checks++;
        if (a_cnt !== 7'd2)
            $display("FAIL rmid_load: got cnt=%0d want 2", a_cnt);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({a_o_vld, a_cnt, a_empty, a_i_rdy} !== {1'b0, 7'd0, 1'b1, 1'b1})
            $display("FAIL rmid_async: got vld=%b cnt=%0d empty=%b rdy=%b want 0 0 1 1",
                     a_o_vld, a_cnt, a_empty, a_i_rdy);
        else n_pass++;
        #1 reset = 1'b0;
        @(negedge clk);
        a_i_vld = 1'b1;
        a_i_dat = 32'h77;
        @(negedge clk);
        a_i_vld = 1'b0;
        n_checks++;
        if ({a_o_vld, a_cnt, a_o_dat} !== {1'b1, 7'd1, 32'h77})
            $display("FAIL rmid_first: got vld=%b cnt=%0d dat=%h want 1 1 77", a_o_vld, a_cnt, a_o_dat);
        else n_pass++;
        a_o_rdy = 1'b1;
        @(negedge clk);
        a_o_rdy = 1'b0;
        n_checks++;
        if (a_empty !== 1'b1)
            $display("FAIL rmid_drain: got empty=%b want 1", a_empty);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_nonpow2();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
